// File: rtl/store_sequencer.sv
// Store sequencer: issues word stores directly and byte/halfword stores as
// read-modify-write through an external size-merge unit, with alignment and timeout checks.
module store_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  command,
  input  logic [31:0] addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [31:0] merged_data,
  output logic [1:0]  ss_command,
  output logic [31:0] mdr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, MERGE, WR_WAIT, DONE, ERROR
  } state_t;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] CMD_BYTE = 2'b01;
  localparam logic [1:0] CMD_HALF = 2'b10;
  localparam logic [1:0] EC_NONE  = 2'b00;
  localparam logic [1:0] EC_ALIGN = 2'b01;
  localparam logic [1:0] EC_TMO   = 2'b10;

  state_t          state_q, state_d;
  logic [1:0]      cmd_q;
  logic [CW-1:0]   wait_cnt;
  logic            is_word, misaligned, accept, in_wait, timed_out;

  // Command codes 00 and 11 both mean word.
  assign is_word    = (command != CMD_BYTE) && (command != CMD_HALF);
  assign misaligned = ((command == CMD_HALF) && addr[0]) ||
                      (is_word && (addr[1:0] != 2'b00));
  assign accept     = (state_q == IDLE) && start;
  assign in_wait    = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  // A ready on the final permitted wait cycle still completes the access.
  assign timed_out  = !mem_ready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a value held, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (misaligned)   state_d = ERROR;
          else if (is_word) state_d = WR_WAIT;
          else              state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        mem_rd = 1'b1;
        if (mem_ready)      state_d = MERGE;
        else if (timed_out) state_d = ERROR;
      end
      MERGE:   state_d = WR_WAIT;
      WR_WAIT: begin
        mem_wr = 1'b1;
        if (mem_ready)      state_d = DONE;
        else if (timed_out) state_d = ERROR;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mdr        <= '0;
      ss_command <= 2'b00;
      err_code   <= EC_NONE;
      wait_cnt   <= '0;
    end else begin
      // The merge unit sees the latched size only while MERGE is active;
      // 00 otherwise so a word store captures the operand unmodified.
      ss_command <= (state_d == MERGE) ? cmd_q : 2'b00;

      if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else if (!in_wait)         wait_cnt <= '0;

      if (accept) begin
        cmd_q    <= command;
        mem_addr <= addr;
        err_code <= misaligned ? EC_ALIGN : EC_NONE;
        if (is_word && !misaligned) mem_wdata <= merged_data;
      end

      if (state_q == RD_WAIT && mem_ready) mdr <= mem_rdata;
      if (state_q == MERGE)                mem_wdata <= merged_data;
      if (in_wait && timed_out)            err_code <= EC_TMO;
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer with a behavioural size-merge unit
// and hand-computed expectations for each scenario.
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  command;
  logic [31:0] addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] merged_data;
  logic [1:0]  ss_command;
  logic [31:0] mdr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] b;

  int total = 0;
  int bad   = 0;
  int dones;

  always #5 clk = ~clk;

  // External merge unit: byte/halfword replace the low lanes of mdr with b.
  assign merged_data = (ss_command == 2'b01) ? {mdr[31:8],  b[7:0]}  :
                       (ss_command == 2'b10) ? {mdr[31:16], b[15:0]} : b;

  store_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .command(command), .addr(addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .merged_data(merged_data),
    .ss_command(ss_command), .mdr(mdr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; command = 2'b00; addr = '0;
    mem_rdata = '0; mem_ready = 1'b0; b = '0;
    #3;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_mem_rd",   32'(mem_rd),   32'd0);
    check("rst_mem_wr",   32'(mem_wr),   32'd0);
    check("rst_mdr",      mdr,           32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_wdata",    mem_wdata,     32'd0);
    tick();
    reset = 1'b1;

    // Byte store, zero-wait memory: done in the fifth cycle.
    start = 1'b1; command = 2'b01; addr = 32'h103; b = 32'h11;
    mem_rdata = 32'hAABBCCDD; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    check("byte_rd",       32'(mem_rd), 32'd1);
    check("byte_rd_nowr",  32'(mem_wr), 32'd0);
    check("byte_rd_addr",  mem_addr,    32'h103);
    check("byte_busy",     32'(busy),   32'd1);
    tick();
    check("byte_mdr",      mdr,             32'hAABBCCDD);
    check("byte_merge_rd", 32'(mem_rd),     32'd0);
    check("byte_ss_cmd",   32'(ss_command), 32'd1);
    tick();
    check("byte_wr",       32'(mem_wr), 32'd1);
    check("byte_wdata",    mem_wdata,   32'hAABBCC11);
    check("byte_wr_addr",  mem_addr,    32'h103);
    tick();
    check("byte_done",     32'(done),   32'd1);
    check("byte_done_wr",  32'(mem_wr), 32'd0);
    tick();
    check("byte_idle_done", 32'(done), 32'd0);
    check("byte_idle_busy", 32'(busy), 32'd0);

    // Misaligned halfword: straight to ERROR, no strobes.
    start = 1'b1; command = 2'b10; addr = 32'h101;
    tick();
    start = 1'b0;
    check("mis_err",      32'(err),      32'd1);
    check("mis_code",     32'(err_code), 32'd1);
    check("mis_no_rd",    32'(mem_rd),   32'd0);
    check("mis_no_wr",    32'(mem_wr),   32'd0);
    tick();
    check("mis_err_off",  32'(err),      32'd0);
    check("mis_code_hold", 32'(err_code), 32'd1);
    check("mis_no_wr2",   32'(mem_wr),   32'd0);

    // Word store, ready on the fourth WR_WAIT cycle.
    start = 1'b1; command = 2'b00; addr = 32'h200; b = 32'hDEADBEEF; mem_ready = 1'b0;
    tick();
    start = 1'b0; b = 32'h0;
    check("word_code_clr", 32'(err_code), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) mem_ready = 1'b1;
      check($sformatf("word_wr_%0d", i), 32'(mem_wr), 32'd1);
      check($sformatf("word_nord_%0d", i), 32'(mem_rd), 32'd0);
      check($sformatf("word_wdata_%0d", i), mem_wdata, 32'hDEADBEEF);
      tick();
    end
    check("word_done",    32'(done),   32'd1);
    check("word_wr_off",  32'(mem_wr), 32'd0);
    check("word_addr",    mem_addr,    32'h200);
    mem_ready = 1'b0;
    tick();

    // Halfword read that never gets ready: 15 read cycles, then timeout.
    start = 1'b1; command = 2'b10; addr = 32'h300;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check($sformatf("tmo_rd_%0d", i), 32'(mem_rd), 32'd1);
      tick();
    end
    check("tmo_err",    32'(err),      32'd1);
    check("tmo_code",   32'(err_code), 32'd2);
    check("tmo_rd_off", 32'(mem_rd),   32'd0);
    tick();
    check("tmo_idle",   32'(busy),     32'd0);

    // Next start after the timeout is accepted normally.
    start = 1'b1; command = 2'b11; addr = 32'h400; b = 32'h12345678; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    check("post_tmo_wr",    32'(mem_wr),   32'd1);
    check("post_tmo_code",  32'(err_code), 32'd0);
    check("post_tmo_wdata", mem_wdata,     32'h12345678);
    tick();
    check("post_tmo_done",  32'(done),     32'd1);
    tick();

    // Ready arriving on the last permitted wait cycle wins over the timeout.
    start = 1'b1; command = 2'b01; addr = 32'h7; mem_ready = 1'b0;
    mem_rdata = 32'h01020304; b = 32'hFF;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) mem_ready = 1'b1;
      tick();
    end
    check("edge_no_err", 32'(err),      32'd0);
    check("edge_merge",  32'(ss_command), 32'd1);
    check("edge_mdr",    mdr,           32'h01020304);
    tick();
    check("edge_wdata",  mem_wdata,     32'h010203FF);
    tick();
    check("edge_done",   32'(done),     32'd1);
    check("edge_code",   32'(err_code), 32'd0);
    tick();

    // Asynchronous reset during WR_WAIT.
    start = 1'b1; command = 2'b00; addr = 32'h800; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("rstmid_wr_pre", 32'(mem_wr), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_wr",   32'(mem_wr),  32'd0);
    check("rstmid_busy", 32'(busy),    32'd0);
    check("rstmid_wdata", mem_wdata,   32'd0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstmid_quiet_wr_%0d", i), 32'(mem_wr), 32'd0);
      check($sformatf("rstmid_quiet_rd_%0d", i), 32'(mem_rd), 32'd0);
    end

    // Second start during RD_WAIT is ignored; exactly one done.
    start = 1'b1; command = 2'b01; addr = 32'h500; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; command = 2'b00; addr = 32'h600;
    tick();
    start = 1'b0; mem_ready = 1'b1;
    tick();
    check("busy_merge_cmd", 32'(ss_command), 32'd1);
    check("busy_addr",      mem_addr,        32'h500);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("busy_one_done", 32'(dones), 32'd1);
    check("busy_idle",     32'(busy),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
